// File: rtl/reservoir_pkg.sv
// Shared types, default weights and sizing helpers for the echo-state reservoir stage.
package reservoir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    ACT,
    COMMIT
  } stateType;

  localparam int RES_N     = 4;
  localparam int DATA_W    = 3;
  localparam int WEIGHT_W  = 16;
  localparam int INPUT_W   = 8;
  localparam int SHIFT_AMT = 4;

  localparam logic [RES_N-1:0][WEIGHT_W-1:0] WIN = '{16'd3, 16'hFFFE, 16'd5, 16'd1};

  localparam logic [RES_N-1:0][RES_N-1:0][WEIGHT_W-1:0] W = '{
    '{16'd2,    16'd0,    16'hFFFF, 16'd1},
    '{16'd0,    16'hFFFD, 16'd1,    16'd0},
    '{16'd1,    16'd2,    16'd0,    16'hFFFE},
    '{16'hFFFF, 16'd0,    16'd3,    16'd2}
  };

  // Wide enough for N+1 signed products so the running sum can never wrap.
  function automatic int accWidth(input int weightW, input int inputW, input int dataW, input int n);
    return weightW + ((inputW > dataW) ? inputW : dataW) + $clog2(n + 1);
  endfunction

  function automatic int idxWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reservoir_weight_rom.sv
// Combinational weight lookup: input weight Win[row] or recurrent weight W[row][col].
module reservoir_weight_rom
  import reservoir_pkg::*;
#(
  parameter int reservoir_size = RES_N,
  parameter int weight_size    = WEIGHT_W,
  parameter logic [reservoir_size-1:0][weight_size-1:0] winWeights = WIN,
  parameter logic [reservoir_size-1:0][reservoir_size-1:0][weight_size-1:0] wWeights = W,
  localparam int IDX_W = idxWidth(reservoir_size)
) (
  input  logic [IDX_W-1:0]              iRow,
  input  logic [IDX_W-1:0]              iCol,
  input  logic                          iIsInput,
  output logic signed [weight_size-1:0] oWeight
);

  always_comb begin
    if (iIsInput) begin
      oWeight = $signed(winWeights[iRow]);
    end else begin
      oWeight = $signed(wWeights[iRow][iCol]);
    end
  end

endmodule

// File: rtl/reservoir_update.sv
// Echo-state reservoir update: x' = sat((Win*u + W*x) >>> shift), one MAC per cycle.
module reservoir_update
  import reservoir_pkg::*;
#(
  parameter int reservoir_size = RES_N,
  parameter int data_width     = DATA_W,
  parameter int weight_size    = WEIGHT_W,
  parameter int input_width    = INPUT_W,
  parameter int shift          = SHIFT_AMT,
  parameter logic [reservoir_size-1:0][weight_size-1:0] winWeights = WIN,
  parameter logic [reservoir_size-1:0][reservoir_size-1:0][weight_size-1:0] wWeights = W
) (
  input  logic                                 iClk,
  input  logic                                 iRst,
  input  logic                                 iEn,
  input  logic signed [input_width-1:0]        iSample,
  output logic [reservoir_size*data_width-1:0] oData,
  output logic                                 oStateRdy,
  output logic                                 oBusy
);

  localparam int IDX_W = idxWidth(reservoir_size);
  localparam int ACC_W = accWidth(weight_size, input_width, data_width, reservoir_size);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(reservoir_size - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (data_width - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  stateType state, stateNext;

  logic signed [input_width-1:0]        sampleReg;
  logic [IDX_W-1:0]                     rowIdx;
  logic [IDX_W-1:0]                     colIdx;
  logic signed [ACC_W-1:0]              acc;
  logic [reservoir_size*data_width-1:0] nextBuf;
  logic signed [weight_size-1:0]        weight;
  logic signed [data_width-1:0]         stateElem;
  logic signed [ACC_W-1:0]              multiplicand;
  logic signed [ACC_W-1:0]              product;
  logic                                 romIsInput;

  function automatic logic signed [data_width-1:0] saturate(input logic signed [ACC_W-1:0] value);
    if (value > SAT_MAX) begin
      return SAT_MAX[data_width-1:0];
    end else if (value < SAT_MIN) begin
      return SAT_MIN[data_width-1:0];
    end else begin
      return value[data_width-1:0];
    end
  endfunction

  reservoir_weight_rom #(
    .reservoir_size(reservoir_size),
    .weight_size   (weight_size),
    .winWeights    (winWeights),
    .wWeights      (wWeights)
  ) weightRom (
    .iRow    (rowIdx),
    .iCol    (colIdx),
    .iIsInput(romIsInput),
    .oWeight (weight)
  );

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = iEn ? LOAD : IDLE;
      LOAD:    stateNext = MAC;
      MAC:     stateNext = (colIdx == LAST_IDX) ? ACT : MAC;
      ACT:     stateNext = (rowIdx == LAST_IDX) ? COMMIT : LOAD;
      COMMIT:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    oBusy      = (state != IDLE);
    romIsInput = (state == LOAD);
  end

  // One shared multiplier: the input term in LOAD, a recurrent term against committed x in MAC.
  always_comb begin
    stateElem    = $signed(oData[colIdx*data_width +: data_width]);
    multiplicand = romIsInput ? ACC_W'(sampleReg) : ACC_W'(stateElem);
    product      = ACC_W'(weight) * multiplicand;
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      sampleReg <= '0;
      rowIdx    <= '0;
      colIdx    <= '0;
      acc       <= '0;
      nextBuf   <= '0;
      oData     <= '0;
      oStateRdy <= 1'b0;
    end else begin
      oStateRdy <= 1'b0;
      case (state)
        IDLE: begin
          if (iEn) begin
            sampleReg <= iSample;
            rowIdx    <= '0;
          end
        end
        LOAD: begin
          acc    <= product;
          colIdx <= '0;
        end
        MAC: begin
          acc    <= acc + product;
          colIdx <= colIdx + 1'b1;
        end
        ACT: begin
          nextBuf[rowIdx*data_width +: data_width] <= saturate(acc >>> shift);
          if (rowIdx != LAST_IDX) begin
            rowIdx <= rowIdx + 1'b1;
          end
        end
        COMMIT: begin
          oData     <= nextBuf;
          oStateRdy <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
